// File: rtl/riscv_pkg.sv
// Shared constants and types for the pipeline front end.
package riscv_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// Generic pipeline register: flush loads a bubble, hold keeps contents.
module ifid_pipe_reg #(
  parameter int unsigned XLEN   = 64,
  parameter logic [31:0] BUBBLE = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  // Flush beats hold; otherwise capture the incoming instruction as valid.
  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      pc_q    <= '0;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, fetch FSM and IF/ID register.
module instruction_fetch_unit #(
  parameter int unsigned XLEN       = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 16,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic [XLEN-1:0] Inst_Address,
  input  logic [31:0]     Instruction,
  output logic [XLEN-1:0] IFID_PC,
  output logic [31:0]     IFID_Instruction,
  output logic            IFID_Valid,
  output logic            Halted,
  output logic            Misaligned_Target
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] LAST_PC  = XLEN'(IMEM_BYTES - INSTR_BYTES);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] PC_RESET = RESET_PC[XLEN-1:0];

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            misal_q, misal_d;
  logic            flush, hold;

  // Next-state, PC and IF/ID control decode; priority branch > stall > normal.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    misal_d  = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    if (state_q == BOOT) begin
      // Redirects are ignored here; IF/ID stays a bubble while the PC settles.
      flush   = 1'b1;
      state_d = RUN;
    end else if (Branch_Taken) begin
      flush    = 1'b1;
      pc_d     = {Branch_Target[XLEN-1:2], 2'b00};
      state_d  = RUN;
      halted_d = 1'b0;
      misal_d  = (Branch_Target[1:0] != 2'b00);
    end else if (Stall) begin
      hold = 1'b1;
    end else if (state_q == HALT) begin
      flush = 1'b1;
    end else if (pc_q > LAST_PC) begin
      // Redirected past the end of memory: nothing to fetch, stop here.
      flush    = 1'b1;
      state_d  = HALT;
      halted_d = 1'b1;
    end else if (pc_q == LAST_PC) begin
      // Capture the last word but keep the PC parked on it.
      state_d  = HALT;
      halted_d = 1'b1;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Fetch FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      misal_q  <= misal_d;
    end
  end

  ifid_pipe_reg #(
    .XLEN   (XLEN),
    .BUBBLE (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .reset_i (reset),
    .hold_i  (hold),
    .flush_i (flush),
    .pc_i    (pc_q),
    .instr_i (Instruction),
    .pc_o    (IFID_PC),
    .instr_o (IFID_Instruction),
    .valid_o (IFID_Valid)
  );

  assign Inst_Address      = pc_q;
  assign Halted            = halted_q;
  assign Misaligned_Target = misal_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 4-word instruction memory.
module tb_instruction_fetch_unit;

  localparam logic [31:0] W0  = 32'h0285_3483;
  localparam logic [31:0] W1  = 32'h009A_84B3;
  localparam logic [31:0] W2  = 32'h0014_8493;
  localparam logic [31:0] W3  = 32'h0295_3423;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, Stall, Branch_Taken;
  logic [63:0] Branch_Target, Inst_Address, IFID_PC;
  logic [31:0] Instruction, IFID_Instruction;
  logic        IFID_Valid, Halted, Misaligned_Target;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  // Combinational little-endian word memory; out-of-range reads return zero.
  always_comb begin
    Instruction = 32'h0;
    if (Inst_Address < 64'd16) begin
      case (Inst_Address[3:2])
        2'd0: Instruction = W0;
        2'd1: Instruction = W1;
        2'd2: Instruction = W2;
        default: Instruction = W3;
      endcase
    end
  end

  instruction_fetch_unit #(
    .XLEN       (64),
    .RESET_PC   (64'h0),
    .IMEM_BYTES (16),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Stall             (Stall),
    .Branch_Taken      (Branch_Taken),
    .Branch_Target     (Branch_Target),
    .Inst_Address      (Inst_Address),
    .Instruction       (Instruction),
    .IFID_PC           (IFID_PC),
    .IFID_Instruction  (IFID_Instruction),
    .IFID_Valid        (IFID_Valid),
    .Halted            (Halted),
    .Misaligned_Target (Misaligned_Target)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full observable state after an edge.
  task automatic expect_all(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                            input logic [31:0] ins, input logic v, input logic h, input logic m);
    chk({tag, ".addr"},   Inst_Address, pc);
    chk({tag, ".ifpc"},   IFID_PC, ipc);
    chk({tag, ".ifins"},  64'(IFID_Instruction), 64'(ins));
    chk({tag, ".valid"},  64'(IFID_Valid), 64'(v));
    chk({tag, ".halted"}, 64'(Halted), 64'(h));
    chk({tag, ".misal"},  64'(Misaligned_Target), 64'(m));
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = '0;
    tick();
    expect_all("reset", 64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_all("boot", 64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    tick();
    expect_all("run0", 64'h4, 64'h0, W0, 1'b1, 1'b0, 1'b0);

    // Stall two cycles at PC=4.
    Stall = 1'b1;
    tick();
    expect_all("stall1", 64'h4, 64'h0, W0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_all("stall2", 64'h4, 64'h0, W0, 1'b1, 1'b0, 1'b0);
    Stall = 1'b0;
    tick();
    expect_all("run1", 64'h8, 64'h4, W1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_all("run2", 64'hC, 64'h8, W2, 1'b1, 1'b0, 1'b0);
    tick();
    expect_all("run3", 64'hC, 64'hC, W3, 1'b1, 1'b1, 1'b0);
    tick();
    expect_all("halt1", 64'hC, 64'h0, NOP, 1'b0, 1'b1, 1'b0);
    tick();
    expect_all("halt2", 64'hC, 64'h0, NOP, 1'b0, 1'b1, 1'b0);

    // Misaligned redirect out of HALT.
    Branch_Taken = 1'b1; Branch_Target = 64'h6;
    tick();
    expect_all("misbr", 64'h4, 64'h0, NOP, 1'b0, 1'b0, 1'b1);
    Branch_Taken = 1'b0;
    tick();
    expect_all("misbr+1", 64'h8, 64'h4, W1, 1'b1, 1'b0, 1'b0);

    // Branch and stall together: branch wins.
    Branch_Taken = 1'b1; Branch_Target = 64'h0; Stall = 1'b1;
    tick();
    expect_all("brstall", 64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    Branch_Taken = 1'b0; Stall = 1'b0;
    tick();
    expect_all("brstall+1", 64'h4, 64'h0, W0, 1'b1, 1'b0, 1'b0);

    // Branch to 8 while PC=4.
    Branch_Taken = 1'b1; Branch_Target = 64'h8;
    tick();
    expect_all("br8", 64'h8, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    Branch_Taken = 1'b0;
    tick();
    expect_all("br8+1", 64'hC, 64'h8, W2, 1'b1, 1'b0, 1'b0);

    // Redirect past end of memory goes straight to HALT without capturing.
    Branch_Taken = 1'b1; Branch_Target = 64'h40;
    tick();
    expect_all("broob", 64'h40, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    Branch_Taken = 1'b0;
    tick();
    expect_all("broob+1", 64'h40, 64'h0, NOP, 1'b0, 1'b1, 1'b0);
    tick();
    expect_all("broob+2", 64'h40, 64'h0, NOP, 1'b0, 1'b1, 1'b0);

    // Reset during a stall at PC=8.
    Branch_Taken = 1'b1; Branch_Target = 64'h8;
    tick();
    expect_all("pre_rst", 64'h8, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    Branch_Taken = 1'b0;
    tick();
    expect_all("pre_rst2", 64'hC, 64'h8, W2, 1'b1, 1'b0, 1'b0);
    Branch_Taken = 1'b1; Branch_Target = 64'h8;
    tick();
    Branch_Taken = 1'b0; Stall = 1'b1;
    tick();
    expect_all("stall8", 64'h8, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    expect_all("midrst", 64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; Stall = 1'b0;
    // Branch during BOOT is ignored.
    Branch_Taken = 1'b1; Branch_Target = 64'h8;
    tick();
    expect_all("bootbr", 64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    Branch_Taken = 1'b0;
    tick();
    expect_all("postrst", 64'h4, 64'h0, W0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
